spi_ram_ctrl: RTL and testbench

Synchronous SPI master that turns single-word read/write requests from the core into SPI RAM transactions using command 03h (read) and 02h (write), mode 0, 24-bit byte address. It drives the external SPI RAM and its simulation model directly. It moves one 32-bit word per transaction.

---
 rtl/spi_ram_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_spi_ram_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// SPI mode-0 master that moves one 32-bit word to or from an SPI RAM per request
// (03h read / 02h write, 24-bit byte address, command MSB first, data LSB first).
module spi_ram_ctrl #(
    parameter int HALF_PERIOD = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        write,
    input  logic [23:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        spi_clk,
    output logic        spi_mosi,
    output logic        spi_select,
    input  logic        spi_miso
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_END
    } state_t;

    localparam logic [3:0] HP = 4'(HALF_PERIOD);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_hp_cnt;
    logic [5:0]  r_bit_cnt;
    logic [31:0] r_shift;
    logic [31:0] r_wdata;
    logic [31:0] r_rx;
    logic [31:0] r_rdata;
    logic        r_write;
    logic        r_busy;
    logic        r_done;
    logic        r_spi_clk;
    logic        r_spi_mosi;
    logic        r_spi_select;

    logic        w_expire;
    logic        w_accept;
    logic        w_rise;
    logic        w_fall;
    logic [31:0] w_cmd_word;

    // The counter reloads to 1 on each toggle but starts from 0 on accept, so the
    // first spi_clk level lasts one extra cycle and done lands at 128*HP+1.
    assign w_expire   = (r_hp_cnt == HP);
    assign w_cmd_word = {(write ? 8'h02 : 8'h03), addr & 24'hFFFFFC};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CMD;
                end
            end
            S_CMD: begin
                w_rise = w_expire && !r_spi_clk;
                w_fall = w_expire && r_spi_clk;
                if (w_fall && r_bit_cnt == 6'd31) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_rise = w_expire && !r_spi_clk;
                w_fall = w_expire && r_spi_clk;
                if (w_fall && r_bit_cnt == 6'd63) begin
                    w_state_next = S_END;
                end
            end
            S_END: begin
                if (w_expire) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hp_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_wdata      <= '0;
            r_rx         <= '0;
            r_rdata      <= '0;
            r_write      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_spi_clk    <= 1'b0;
            r_spi_mosi   <= 1'b0;
            r_spi_select <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift      <= {w_cmd_word[30:0], 1'b0};
                        r_spi_mosi   <= w_cmd_word[31];
                        r_wdata      <= wdata;
                        r_write      <= write;
                        r_busy       <= 1'b1;
                        r_spi_select <= 1'b0;
                        r_spi_clk    <= 1'b0;
                        r_hp_cnt     <= '0;
                        r_bit_cnt    <= '0;
                    end
                end
                S_CMD, S_DATA: begin
                    if (w_expire) begin
                        r_spi_clk <= ~r_spi_clk;
                        r_hp_cnt  <= 4'd1;
                    end else begin
                        r_hp_cnt <= r_hp_cnt + 4'd1;
                    end
                    if (w_rise && r_state == S_DATA) begin
                        r_rx <= {spi_miso, r_rx[31:1]};
                    end
                    if (w_fall) begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                        if (r_state == S_CMD) begin
                            if (r_bit_cnt == 6'd31) begin
                                r_spi_mosi <= r_write & r_wdata[0];
                            end else begin
                                r_spi_mosi <= r_shift[31];
                                r_shift    <= {r_shift[30:0], 1'b0};
                            end
                        end else if (r_bit_cnt != 6'd63) begin
                            r_spi_mosi <= r_write & r_wdata[1];
                            r_wdata    <= {1'b0, r_wdata[31:1]};
                        end else begin
                            // Last fall: deselect and report on the same edge.
                            r_spi_select <= 1'b1;
                            r_spi_mosi   <= 1'b0;
                            r_done       <= 1'b1;
                            r_busy       <= 1'b0;
                            r_bit_cnt    <= '0;
                            if (!r_write) begin
                                r_rdata <= r_rx;
                            end
                        end
                    end
                end
                S_END: begin
                    if (w_expire) begin
                        r_hp_cnt <= '0;
                    end else begin
                        r_hp_cnt <= r_hp_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign rdata      = r_rdata;
    assign spi_clk    = r_spi_clk;
    assign spi_mosi   = r_spi_mosi;
    assign spi_select = r_spi_select;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: two instances (HALF_PERIOD 1 and 3) share a behavioural
// SPI RAM model; directed table, corner sequences and random traffic are scored.
module tb_spi_ram_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  start_s;
    logic [1:0]  write_s;
    logic [23:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [1:0]  busy_w;
    logic [1:0]  done_w;
    logic [31:0] rdata_w [2];
    logic [1:0]  sclk_w;
    logic [1:0]  mosi_w;
    logic [1:0]  sel_w;
    logic [1:0]  miso_d = 2'b00;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.HALF_PERIOD(1)) u_dut0 (
        .clk(clk), .rstn(rstn), .start(start_s[0]), .write(write_s[0]),
        .addr(addr_s[0]), .wdata(wdata_s[0]), .busy(busy_w[0]), .done(done_w[0]),
        .rdata(rdata_w[0]), .spi_clk(sclk_w[0]), .spi_mosi(mosi_w[0]),
        .spi_select(sel_w[0]), .spi_miso(miso_d[0])
    );

    spi_ram_ctrl #(.HALF_PERIOD(3)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start_s[1]), .write(write_s[1]),
        .addr(addr_s[1]), .wdata(wdata_s[1]), .busy(busy_w[1]), .done(done_w[1]),
        .rdata(rdata_w[1]), .spi_clk(sclk_w[1]), .spi_mosi(mosi_w[1]),
        .spi_select(sel_w[1]), .spi_miso(miso_d[1])
    );

    function automatic int hp(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int ram_key(input int g, input logic [23:0] a);
        return (g << 22) | int'(a[23:2]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- SPI RAM model (sampled on falling clk) ----------------
    logic [31:0] ram_mem [int];
    logic [1:0]  sel_prev  = 2'b11;
    logic [1:0]  sclk_prev = 2'b00;
    logic [1:0]  mosi_prev = 2'b00;
    int          tick = 0;
    int          rises     [2];
    int          last_rise [2];
    int          gap_min   [2];
    int          gap_max   [2];
    logic [31:0] cmd_bits  [2];
    logic [31:0] data_bits [2];
    int          n_txn     [2];
    int          res_rises [2];
    int          res_gmin  [2];
    int          res_gmax  [2];
    logic [31:0] res_cmd   [2];
    logic [31:0] res_data  [2];
    int          clk_bad   [2];

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            logic [31:0] word;
            int          key;
            if (sel_w[g] !== sel_prev[g] && sclk_w[g] !== 1'b0) clk_bad[g]++;
            if (sel_prev[g] && !sel_w[g]) begin
                rises[g] = 0; cmd_bits[g] = '0; data_bits[g] = '0;
                gap_min[g] = 1000000; gap_max[g] = 0;
            end
            if (sel_w[g] === 1'b0) begin
                if (sclk_w[g] && !sclk_prev[g]) begin
                    if (rises[g] > 0) begin
                        if (tick - last_rise[g] < gap_min[g]) gap_min[g] = tick - last_rise[g];
                        if (tick - last_rise[g] > gap_max[g]) gap_max[g] = tick - last_rise[g];
                    end
                    last_rise[g] = tick;
                    if (rises[g] < 32) cmd_bits[g] = {cmd_bits[g][30:0], mosi_prev[g]};
                    else if (rises[g] < 64) data_bits[g][rises[g] - 32] = mosi_prev[g];
                    rises[g]++;
                end
                if (!sclk_w[g] && sclk_prev[g] && rises[g] >= 32 && rises[g] < 64
                    && cmd_bits[g][31:24] == 8'h03) begin
                    key  = ram_key(g, cmd_bits[g][23:0]);
                    word = ram_mem.exists(key) ? ram_mem[key] : 32'h0;
                    miso_d[g] = word[rises[g] - 32];
                end
            end
            if (!sel_prev[g] && sel_w[g]) begin
                res_rises[g] = rises[g]; res_cmd[g] = cmd_bits[g]; res_data[g] = data_bits[g];
                res_gmin[g] = gap_min[g]; res_gmax[g] = gap_max[g];
                if (rises[g] == 64 && cmd_bits[g][31:24] == 8'h02)
                    ram_mem[ram_key(g, cmd_bits[g][23:0])] = data_bits[g];
                n_txn[g]++;
                rises[g] = 0;
                miso_d[g] = 1'b0;
            end
            sel_prev[g]  = sel_w[g];
            sclk_prev[g] = sclk_w[g];
            mosi_prev[g] = mosi_w[g];
        end
        tick++;
    end

    // ---------------- scoreboard and transaction driver ----------------
    logic [31:0] sb_mem [int];
    logic [31:0] exp_rdata [2];

    // mode 0: plain, 1: extra start pulses at cycles 5 and 129, 2: reset at cycle 70
    task automatic run_txn(input int g, input logic wr, input logic [23:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_cmd,
                           input logic [31:0] exp_rd, input int mode);
        int h, cyc, gaps, lim, n0, bad;
        h   = hp(g);
        lim = 128 * h + 40;
        n0  = n_txn[g];
        repeat (4 * h + 2) @(negedge clk);
        start_s[g] = 1'b1; write_s[g] = wr; addr_s[g] = a; wdata_s[g] = wd;
        @(negedge clk);
        start_s[g] = 1'b0;
        check("accept_busy", 32'(busy_w[g]), 1);
        check("accept_select", 32'(sel_w[g]), 0);
        cyc  = 0;
        gaps = 0;
        while (done_w[g] !== 1'b1 && cyc < lim) begin
            if (mode == 2 && cyc == 70) break;
            if (mode == 1) begin
                start_s[g] = (cyc == 4 || cyc == 128);
                write_s[g] = 1'b0;
                addr_s[g]  = 24'h000020;
            end
            @(negedge clk);
            cyc++;
            if (done_w[g] !== 1'b1 && busy_w[g] !== 1'b1) gaps++;
        end
        start_s[g] = 1'b0;

        if (mode == 2) begin
            #1 rstn = 1'b0;
            #1;
            check("abort_select", 32'(sel_w[g]), 1);
            check("abort_sclk", 32'(sclk_w[g]), 0);
            check("abort_mosi", 32'(mosi_w[g]), 0);
            check("abort_busy", 32'(busy_w[g]), 0);
            check("abort_rdata", rdata_w[g], 0);
            check("abort_rdata_other", rdata_w[1 - g], 0);
            exp_rdata[0] = '0;
            exp_rdata[1] = '0;
            bad = 0;
            repeat (3) begin
                @(negedge clk);
                if (done_w[g] !== 1'b0) bad++;
            end
            rstn = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (done_w[g] !== 1'b0) bad++;
            end
            check("abort_no_done", bad, 0);
            check("abort_txn_count", n_txn[g], n0 + 1);
            check("abort_rises", res_rises[g], (70 - 1 + h) / (2 * h));
            return;
        end

        check("latency", cyc, 128 * h + 1);
        check("busy_continuous", gaps, 0);
        check("done_busy", 32'(busy_w[g]), 0);
        check("done_select", 32'(sel_w[g]), 1);
        check("done_sclk", 32'(sclk_w[g]), 0);
        if (wr) begin
            check("rdata_kept", rdata_w[g], exp_rdata[g]);
        end else begin
            check("rdata", rdata_w[g], exp_rd);
            exp_rdata[g] = exp_rd;
        end
        @(negedge clk);
        check("done_pulse", 32'(done_w[g]), 0);
        if (mode == 1) begin
            bad = 0;
            repeat (20) begin
                @(negedge clk);
                if (busy_w[g] !== 1'b0 || sel_w[g] !== 1'b1) bad++;
            end
            check("poke_ignored", bad, 0);
        end
        check("txn_count", n_txn[g], n0 + 1);
        check("rises", res_rises[g], 64);
        check("cmd_bits", res_cmd[g], exp_cmd);
        check("data_bits", res_data[g], wr ? wd : 32'h0);
        check("sclk_period_min", res_gmin[g], 2 * h);
        check("sclk_period_max", res_gmax[g], 2 * h);
        check("sclk_low_at_select", clk_bad[g], 0);
    endtask

    typedef struct {
        int          g;
        logic        wr;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_cmd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] pool [4];
        logic [23:0] a;
        logic [31:0] wd;
        logic        wr;
        int          key;

        vecs[0] = '{0, 1'b1, 24'h000010, 32'hDEADBEEF, 32'h02000010, 32'h0};
        vecs[1] = '{0, 1'b0, 24'h000013, 32'h0,        32'h03000010, 32'hDEADBEEF};
        vecs[2] = '{0, 1'b1, 24'hABCDEF, 32'h0F1E2D3C, 32'h02ABCDEC, 32'h0};
        vecs[3] = '{0, 1'b0, 24'hABCDEC, 32'h0,        32'h03ABCDEC, 32'h0F1E2D3C};
        vecs[4] = '{0, 1'b0, 24'h000100, 32'h0,        32'h03000100, 32'h0};
        vecs[5] = '{1, 1'b1, 24'h000040, 32'h12345678, 32'h02000040, 32'h0};
        vecs[6] = '{1, 1'b0, 24'h000042, 32'h0,        32'h03000040, 32'h12345678};

        rstn = 1'b0;
        start_s = '0; write_s = '0;
        for (int g = 0; g < 2; g++) begin
            addr_s[g] = '0; wdata_s[g] = '0; exp_rdata[g] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_select", 32'(sel_w[0]), 1);
        check("reset_sclk", 32'(sclk_w[0]), 0);
        check("reset_mosi", 32'(mosi_w[0]), 0);
        check("reset_busy", 32'(busy_w[0]), 0);
        check("reset_done", 32'(done_w[0]), 0);
        check("reset_rdata", rdata_w[0], 0);
        check("reset_select_hp3", 32'(sel_w[1]), 1);
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].g, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_cmd, vecs[i].exp_rd, 0);
            if (vecs[i].wr) sb_mem[ram_key(vecs[i].g, vecs[i].addr)] = vecs[i].wdata;
        end

        // Ignored start pulses while busy and on the done edge.
        run_txn(0, 1'b0, 24'h000010, 32'h0, 32'h03000010, 32'hDEADBEEF, 1);
        // Reset mid-read, then a fresh read.
        run_txn(0, 1'b0, 24'h000010, 32'h0, 32'h03000010, 32'h0, 2);
        run_txn(0, 1'b0, 24'h000010, 32'h0, 32'h03000010, 32'hDEADBEEF, 0);

        for (int i = 0; i < 4; i++) pool[i] = 24'($urandom);
        for (int i = 0; i < 20; i++) begin
            a   = pool[$urandom_range(0, 3)] ^ 24'($urandom_range(0, 3));
            wr  = 1'($urandom_range(0, 1));
            wd  = $urandom;
            key = ram_key(0, a);
            run_txn(0, wr, a, wd, {(wr ? 8'h02 : 8'h03), a[23:2], 2'b00},
                    sb_mem.exists(key) ? sb_mem[key] : 32'h0, 0);
            if (wr) sb_mem[key] = wd;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
